// File: rtl/reg_bank8_rw.sv
// reg_bank8_rw: eight-entry register storage bank with one write port and two
// registered read ports, feeding the register-file read-select muxes.
//
// Parameters:
//   WIDTH      - data width of each entry and of every data port.
//   ZERO_ENTRY - when 1, entry 7 is hardwired to zero (reads 0, writes dropped).
//
// Ports:
//   clk        - clock, rising-edge active.
//   reset_n    - asynchronous active-low reset.
//   clear      - synchronous clear of all entries and wr_count; beats wr_en.
//   wr_en      - write strobe.
//   wr_addr    - write entry index.
//   wr_data    - write data.
//   rd_en      - read request, captures both read ports.
//   rd_addr_a  - read port A index.
//   rd_addr_b  - read port B index.
//   rd_data_a  - registered read data, port A.
//   rd_data_b  - registered read data, port B.
//   rd_valid   - high for the cycle after an accepted rd_en.
//   wr_count   - saturating count of accepted writes (debug).
module reg_bank8_rw #(
  parameter int unsigned WIDTH      = 64,
  parameter bit          ZERO_ENTRY = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic [3:0]       wr_count
);

  localparam logic [2:0] ZeroAddr = 3'd7;

  logic [WIDTH-1:0] entry_q [8];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_valid_q;
  logic [3:0]       wr_count_q, wr_count_d;
  logic             wr_discard;
  logic             wr_accept;
  logic [WIDTH-1:0] mux_a, mux_b;

  // A write to the hardwired entry is dropped: no storage update, no count,
  // no forwarding.
  assign wr_discard = ZERO_ENTRY && (wr_addr == ZeroAddr);
  assign wr_accept  = wr_en && !clear && !wr_discard;

  // Per-bit 8:1 selection; the hardwired entry is forced to zero after the
  // mux so its (never written) flop contents cannot leak out.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int unsigned bit_idx = 0; bit_idx < WIDTH; bit_idx++) begin
      mux_a[bit_idx] = entry_q[rd_addr_a][bit_idx];
      mux_b[bit_idx] = entry_q[rd_addr_b][bit_idx];
    end
    if (ZERO_ENTRY && (rd_addr_a == ZeroAddr)) mux_a = '0;
    if (ZERO_ENTRY && (rd_addr_b == ZeroAddr)) mux_b = '0;
  end

  // Read capture: clear wins, then same-edge write forwarding, then storage.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_en) begin
      if (clear) begin
        rd_data_a_d = '0;
        rd_data_b_d = '0;
      end else begin
        rd_data_a_d = (wr_accept && (wr_addr == rd_addr_a)) ? wr_data : mux_a;
        rd_data_b_d = (wr_accept && (wr_addr == rd_addr_b)) ? wr_data : mux_b;
      end
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (clear) begin
      wr_count_d = '0;
    end else if (wr_accept && (wr_count_q != 4'hF)) begin
      wr_count_d = wr_count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        entry_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < 8; i++) begin
        entry_q[i] <= '0;
      end
    end else if (wr_accept) begin
      entry_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_en;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_bank8_rw.sv
// Scoreboard bench for reg_bank8_rw: one instance with ZERO_ENTRY=1 and one
// with ZERO_ENTRY=0 share stimulus; expected read results are queued per
// instance at issue time and popped by a monitor whenever rd_valid is high.
module tb_reg_bank8_rw;

  localparam int unsigned W = 64;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         rd_en;
  logic [2:0]   rd_addr_a;
  logic [2:0]   rd_addr_b;

  logic [W-1:0] rd_data_a1, rd_data_b1, rd_data_a0, rd_data_b0;
  logic         rd_valid1, rd_valid0;
  logic [3:0]   wr_count1, wr_count0;

  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int max_run = 0;

  logic [2*W-1:0] q1[$];
  logic [2*W-1:0] q0[$];

  reg_bank8_rw #(.WIDTH(W), .ZERO_ENTRY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1), .rd_valid(rd_valid1),
    .wr_count(wr_count1)
  );

  reg_bank8_rw #(.WIDTH(W), .ZERO_ENTRY(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0), .rd_valid(rd_valid0),
    .wr_count(wr_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic we, input logic [2:0] wa, input logic [W-1:0] wd,
                      input logic re, input logic [2:0] ra, input logic [2:0] rb,
                      input logic clr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr_a = ra; rd_addr_b = rb; clear = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic expect_rd(input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input logic [W-1:0] a0, input logic [W-1:0] b0);
    q1.push_back({a1, b1});
    q0.push_back({a0, b0});
  endtask

  task automatic idle();
    step(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rd_valid1 || rd_valid0) begin
      chk("rd_valid_agree", {63'd0, rd_valid0}, {63'd0, rd_valid1});
    end
    if (rd_valid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_z1: rd_valid=1 with nothing expected");
      end else begin
        e = q1.pop_front();
        chk("rd_data_a_z1", rd_data_a1, e[2*W-1:W]);
        chk("rd_data_b_z1", rd_data_b1, e[W-1:0]);
      end
    end
    if (rd_valid0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_z0: rd_valid=1 with nothing expected");
      end else begin
        e = q0.pop_front();
        chk("rd_data_a_z0", rd_data_a0, e[2*W-1:W]);
        chk("rd_data_b_z0", rd_data_b0, e[W-1:0]);
      end
    end
    if (rd_valid1) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] stream_exp [8];

  initial begin
    stream_exp = '{64'h100E, 64'h100F, 64'h1010, 64'h1011,
                   64'h1012, 64'h1013, 64'h100D, 64'h0};
    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    #12;
    chk("reset_rd_data_a", rd_data_a1, '0);
    chk("reset_rd_valid", {63'd0, rd_valid1}, '0);
    chk("reset_wr_count", {60'd0, wr_count1}, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset sequence: make outputs non-zero, then reset asynchronously.
    step(1'b1, 3'd3, 64'hAAAA, 1'b0, 3'd0, 3'd0, 1'b0);
    expect_rd(64'hAAAA, 64'hAAAA, 64'hAAAA, 64'hAAAA);
    step(1'b0, 3'd0, '0, 1'b1, 3'd3, 3'd3, 1'b0);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd_data_a", rd_data_a1, '0);
    chk("async_rst_rd_data_b", rd_data_b0, '0);
    chk("async_rst_rd_valid", {63'd0, rd_valid1}, '0);
    chk("async_rst_wr_count", {60'd0, wr_count1}, '0);
    // Read and write presented while reset is held: both must be lost.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 64'h1111;
    rd_en = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    @(posedge clk); #2;
    wr_en = 1'b0; rd_en = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rd_valid", {63'd0, rd_valid1}, '0);
    chk("post_rst_wr_count", {60'd0, wr_count0}, '0);
    expect_rd(64'h0, 64'h0, 64'h0, 64'h0);
    step(1'b0, 3'd0, '0, 1'b1, 3'd3, 3'd3, 1'b0);
    idle();

    // Write then read, with data held on the following idle cycle.
    step(1'b1, 3'd2, 64'h1234, 1'b0, 3'd0, 3'd0, 1'b0);
    expect_rd(64'h1234, 64'h0, 64'h1234, 64'h0);
    step(1'b0, 3'd0, '0, 1'b1, 3'd2, 3'd5, 1'b0);
    idle();
    chk("idle_rd_valid", {63'd0, rd_valid1}, '0);
    chk("idle_hold_rd_data_a", rd_data_a1, 64'h1234);
    chk("wr_count_after_1", {60'd0, wr_count1}, 64'd1);

    // Same-edge forwarding on both ports, then a plain read of the entry.
    expect_rd(64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD);
    step(1'b1, 3'd4, 64'hDEAD, 1'b1, 3'd4, 3'd4, 1'b0);
    expect_rd(64'hDEAD, 64'h1234, 64'hDEAD, 64'h1234);
    step(1'b0, 3'd0, '0, 1'b1, 3'd4, 3'd2, 1'b0);
    idle();

    // Write to entry 7 with same-edge read: hardwired vs ordinary storage.
    expect_rd(64'h0, 64'h0, 64'hFFFF, 64'h0);
    step(1'b1, 3'd7, 64'hFFFF, 1'b1, 3'd7, 3'd0, 1'b0);
    idle();
    chk("zero_entry_wr_count_z1", {60'd0, wr_count1}, 64'd2);
    chk("zero_entry_wr_count_z0", {60'd0, wr_count0}, 64'd3);
    expect_rd(64'h0, 64'h0, 64'hFFFF, 64'hFFFF);
    step(1'b0, 3'd0, '0, 1'b1, 3'd7, 3'd7, 1'b0);
    idle();

    // Clear priority over a simultaneous write and read.
    for (int i = 0; i < 7; i++) step(1'b1, 3'(i), 64'h100 + 64'(i), 1'b0, 3'd0, 3'd0, 1'b0);
    chk("fill_wr_count_z0", {60'd0, wr_count0}, 64'd10);
    expect_rd(64'h0, 64'h0, 64'h0, 64'h0);
    step(1'b1, 3'd1, 64'h55, 1'b1, 3'd1, 3'd6, 1'b1);
    idle();
    chk("clear_wr_count_z1", {60'd0, wr_count1}, '0);
    chk("clear_wr_count_z0", {60'd0, wr_count0}, '0);
    for (int i = 0; i < 4; i++) begin
      expect_rd(64'h0, 64'h0, 64'h0, 64'h0);
      step(1'b0, 3'd0, '0, 1'b1, 3'(i), 3'(i + 4), 1'b0);
    end
    idle();

    // Saturation: 20 accepted writes on both, plus one to entry 7.
    for (int k = 0; k < 20; k++) step(1'b1, 3'(k % 7), 64'h1000 + 64'(k), 1'b0, 3'd0, 3'd0, 1'b0);
    step(1'b1, 3'd7, 64'h7777, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("sat_wr_count_z1", {60'd0, wr_count1}, 64'd15);
    chk("sat_wr_count_z0", {60'd0, wr_count0}, 64'd15);

    // Streaming: eight back-to-back reads of entries 0-7.
    for (int i = 0; i < 8; i++) begin
      expect_rd(stream_exp[i], stream_exp[7 - i],
                (i == 7) ? 64'h7777 : stream_exp[i],
                (i == 0) ? 64'h7777 : stream_exp[7 - i]);
      step(1'b0, 3'd0, '0, 1'b1, 3'(i), 3'(7 - i), 1'b0);
    end
    idle();
    idle();

    chk("stream_valid_run", 64'(max_run), 64'd8);
    chk("queue_drained_z1", 64'(q1.size()), 64'd0);
    chk("queue_drained_z0", 64'(q0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
